ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 SHALL have ports: clk input 1 system clock; reset input 1 asynchronous, active-high.
REQ-002 SHALL have en input 1: fetch advance enable, 0 = stall, hold PC.
REQ-003 SHALL have npc_sel input 2: next-PC source (0 seq, 1 branch, 2 j/jal, 3 jr/jalr), driven by the D-stage decoder.
REQ-004 SHALL have br_taken input 1: D-stage branch comparison result.
REQ-005 SHALL have d_pc input 32: PC of the instruction currently in D.
REQ-006 SHALL have imm16 input 16 and index26 input 26: D-stage branch offset and jump index.
REQ-007 SHALL have jr_target input 32: forwarded rs value for jr/jalr.
REQ-008 SHALL have exc_req input 1: exception/interrupt flush from the CP0 stage; eret input 1: eret in D; epc input 32: CP0 EPC.
REQ-009 SHALL have i_addr output 32 (instruction memory address) and i_rdata input 32 (combinational instruction memory read data).
REQ-010 SHALL have f_pc output 32, f_instr output 32, f_exccode output 5 and f_bd output 1, all feeding the F/D pipeline register.

Function
REQ-011 SHALL hold PC in one 32-bit register; i_addr = f_pc = PC, combinationally.
REQ-012 SHALL update PC on posedge clk by priority: exc_req -> 0x0000_4180 (ignores en); else eret & en -> epc; else en=0 -> hold; else per npc_sel.
REQ-013 SHALL use npc_sel=0: PC+4.
REQ-014 SHALL use npc_sel=1: d_pc + 4 + (sign_extend(imm16) << 2) if br_taken, else PC+4.
REQ-015 SHALL use npc_sel=2: {d_pc[31:28], index26, 2'b00}; npc_sel=3: jr_target.
REQ-016 SHALL compute all additions modulo 2^32, with no overflow detection.
REQ-017 SHALL assert f_bd = 1 when npc_sel != 0, marking the F instruction as a delay slot, even for a not-taken branch.
REQ-018 SHALL force f_bd = 0 when eret = 1, because the instruction after eret is not a delay slot.
REQ-019 SHALL pass f_instr = i_rdata unless REQ-026 applies.
REQ-020 SHALL give exc_req and en=0 in the same cycle this result: PC <= 0x0000_4180.
REQ-021 SHALL give eret and en=0 in the same cycle this result: PC holds, and the redirect occurs on the first en=1 cycle.
REQ-022 SHALL give a PC of 0xFFFF_FFFC with npc_sel=0 this next PC: 0x0000_0000, by wrap-around.

Reset
REQ-023 SHALL make reset asynchronous and active-high, forcing PC = 0x0000_3000 immediately, independent of clk.
REQ-024 SHALL, during reset, drive f_pc = i_addr = 0x0000_3000 and f_exccode = 0, with f_bd following REQ-017/018.
REQ-025 SHALL resume fetch on the first posedge after deassertion, applying REQ-012 normally.

Configuration
REQ-026 SHALL, with IFU_ADEL_EN defined, detect fetch address errors, each of which is an error: PC[1:0] != 0, PC < 0x0000_3000, or PC > 0x0000_6FFC.
REQ-027 SHALL, with IFU_ADEL_EN defined, drive f_exccode = 5'd4 (AdEL) and f_instr = 0x0000_0000 on a fetch address error, while f_pc still shows the faulting PC.
REQ-028 SHALL, without IFU_ADEL_EN, tie f_exccode to 0, pass i_rdata unconditionally, and include no range-check logic.

Verification
REQ-029 SHALL cover reset: assert reset mid-cycle with PC=0x3010 -> f_pc=0x3000 immediately; after release with en=1 and npc_sel=0, f_pc=0x3004 next cycle.
REQ-030 SHALL cover branch taken: d_pc=0x3008, imm16=0xFFFE, npc_sel=1, br_taken=1 -> next PC=0x3004, f_bd=1; with br_taken=0 -> PC+4, f_bd=1.
REQ-031 SHALL cover jumps: npc_sel=2, d_pc=0x3000, index26=0x0000C10 -> PC=0x0000_3040; npc_sel=3, jr_target=0x3100 -> PC=0x3100.
REQ-032 SHALL cover stall versus exception: en=0 for 3 cycles -> PC constant; en=0 with exc_req=1 -> PC=0x4180 next cycle.
REQ-033 SHALL cover eret: eret=1, epc=0x3024, en=1 -> PC=0x3024, f_bd=0; eret=1, en=0 -> hold until en=1.
REQ-034 SHALL cover IFU_ADEL_EN: jr_target=0x3002 -> f_exccode=4, f_instr=0; jr_target=0x7000 -> f_exccode=4; without the macro -> f_exccode=0 and f_instr=i_rdata.

Source files
------------

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, next-PC selection and fetch outputs.
// Optional fetch address-error (AdEL) detection is enabled by defining IFU_ADEL_EN.
module ifu (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] d_pc,
    input  logic [15:0] imm16,
    input  logic [25:0] index26,
    input  logic [31:0] jr_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] i_addr,
    input  logic [31:0] i_rdata,
    output logic [31:0] f_pc,
    output logic [31:0] f_instr,
    output logic [4:0]  f_exccode,
    output logic        f_bd
);

    localparam logic [31:0] ResetPc = 32'h0000_3000;
    localparam logic [31:0] ExcPc   = 32'h0000_4180;

    logic [31:0] pc_q, pc_d;
    logic [31:0] seq_pc, br_pc, br_off;

    always_comb begin
        br_off = {{14{imm16[15]}}, imm16, 2'b00};
        seq_pc = pc_q + 32'd4;
        br_pc  = d_pc + 32'd4 + br_off;
    end

    // Exception redirect wins over everything, including a stall.
    always_comb begin
        pc_d = pc_q;
        if (exc_req) begin
            pc_d = ExcPc;
        end else if (eret && en) begin
            pc_d = epc;
        end else if (en) begin
            unique case (npc_sel)
                2'd0: pc_d = seq_pc;
                2'd1: pc_d = br_taken ? br_pc : seq_pc;
                2'd2: pc_d = {d_pc[31:28], index26, 2'b00};
                2'd3: pc_d = jr_target;
                default: pc_d = seq_pc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= ResetPc;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign i_addr = pc_q;
    assign f_pc   = pc_q;
    // Any non-sequential D instruction makes F a delay slot, except after eret.
    assign f_bd   = (npc_sel != 2'd0) && !eret;

`ifdef IFU_ADEL_EN
    logic adel;
    assign adel      = (pc_q[1:0] != 2'b00) || (pc_q < 32'h0000_3000) || (pc_q > 32'h0000_6FFC);
    assign f_exccode = adel ? 5'd4 : 5'd0;
    assign f_instr   = adel ? 32'h0000_0000 : i_rdata;
`else
    assign f_exccode = 5'd0;
    assign f_instr   = i_rdata;
`endif

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed vector table, corner sequences and
// randomized stimulus against a spec-level next-PC model.
module tb_ifu;

    typedef struct {
        logic [31:0] start_pc;
        logic        en;
        logic [1:0]  npc_sel;
        logic        br_taken;
        logic [31:0] d_pc;
        logic [15:0] imm16;
        logic [25:0] index26;
        logic [31:0] jr_target;
        logic        exc_req;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] exp_pc;
        logic        exp_bd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [31:0] d_pc;
    logic [15:0] imm16;
    logic [25:0] index26;
    logic [31:0] jr_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic [4:0]  f_exccode;
    logic        f_bd;

    int errors = 0;
    int checks = 0;
    vec_t vecs[10];
    logic [31:0] model_pc;

    ifu dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .npc_sel   (npc_sel),
        .br_taken  (br_taken),
        .d_pc      (d_pc),
        .imm16     (imm16),
        .index26   (index26),
        .jr_target (jr_target),
        .exc_req   (exc_req),
        .eret      (eret),
        .epc       (epc),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .f_pc      (f_pc),
        .f_instr   (f_instr),
        .f_exccode (f_exccode),
        .f_bd      (f_bd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b1; npc_sel = 2'd0; br_taken = 1'b0; d_pc = 32'h0; imm16 = 16'h0;
        index26 = 26'h0; jr_target = 32'h0; exc_req = 1'b0; eret = 1'b0; epc = 32'h0;
    endtask

    task automatic set_pc(input logic [31:0] pc);
        idle_inputs();
        npc_sel = 2'd3;
        jr_target = pc;
        tick();
        idle_inputs();
        #1;
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic e, input logic [1:0] sel,
                                             input logic bt, input logic [31:0] dpc,
                                             input logic [15:0] imm, input logic [25:0] idx,
                                             input logic [31:0] jr, input logic x, input logic er,
                                             input logic [31:0] ep);
        logic [31:0] off;
        off = {{16{imm[15]}}, imm};
        if (x) return 32'h0000_4180;
        if (er && e) return ep;
        if (!e) return pc;
        case (sel)
            2'd1: return bt ? (dpc + 32'd4 + off * 32'd4) : (pc + 32'd4);
            2'd2: return (dpc & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
            2'd3: return jr;
            default: return pc + 32'd4;
        endcase
    endfunction

    function automatic logic is_adel(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
    endfunction

    initial begin
        //               start     en sel bt d_pc      imm16     idx26       jr        x  er epc       exp_pc    bd
        vecs[0] = '{32'h3000, 1, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h0, 32'h3004, 0};
        vecs[1] = '{32'h3010, 1, 1, 1, 32'h3008, 16'hFFFE, 26'h0, 32'h0, 0, 0, 32'h0, 32'h3004, 1};
        vecs[2] = '{32'h3010, 1, 1, 0, 32'h3008, 16'hFFFE, 26'h0, 32'h0, 0, 0, 32'h0, 32'h3014, 1};
        vecs[3] = '{32'h3004, 1, 2, 0, 32'h3000, 16'h0, 26'h0000C10, 32'h0, 0, 0, 32'h0, 32'h3040, 1};
        vecs[4] = '{32'h3004, 1, 3, 0, 32'h0, 16'h0, 26'h0, 32'h3100, 0, 0, 32'h0, 32'h3100, 1};
        vecs[5] = '{32'hFFFF_FFFC, 1, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0};
        vecs[6] = '{32'h3020, 0, 3, 0, 32'h0, 16'h0, 26'h0, 32'h5000, 1, 0, 32'h0, 32'h4180, 1};
        vecs[7] = '{32'h3000, 1, 1, 1, 32'h3000, 16'h0, 26'h0, 32'h0, 0, 1, 32'h3024, 32'h3024, 0};
        vecs[8] = '{32'h3000, 1, 1, 1, 32'h3008, 16'h0010, 26'h0, 32'h0, 0, 0, 32'h0, 32'h304C, 1};
        vecs[9] = '{32'h3000, 0, 2, 0, 32'h3000, 16'h0, 26'h1234, 32'h0, 0, 0, 32'h0, 32'h3000, 1};

        idle_inputs();
        i_rdata = 32'hDEAD_BEEF;
        reset = 1'b1;
        #1;
        check("reset_pc", f_pc, 32'h3000);
        check("reset_iaddr", i_addr, 32'h3000);
        check("reset_exccode", {27'd0, f_exccode}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("first_fetch", f_pc, 32'h3004);

        foreach (vecs[i]) begin
            set_pc(vecs[i].start_pc);
            en = vecs[i].en; npc_sel = vecs[i].npc_sel; br_taken = vecs[i].br_taken;
            d_pc = vecs[i].d_pc; imm16 = vecs[i].imm16; index26 = vecs[i].index26;
            jr_target = vecs[i].jr_target; exc_req = vecs[i].exc_req; eret = vecs[i].eret;
            epc = vecs[i].epc;
            #1;
            check($sformatf("vec%0d_bd", i), {31'd0, f_bd}, {31'd0, vecs[i].exp_bd});
            tick();
            check($sformatf("vec%0d_pc", i), f_pc, vecs[i].exp_pc);
        end

        // Asynchronous reset mid-cycle
        set_pc(32'h3010);
        check("pre_reset_pc", f_pc, 32'h3010);
        #2 reset = 1'b1;
        npc_sel = 2'd1;
        #1;
        check("async_reset_pc", f_pc, 32'h3000);
        check("reset_bd_follows_sel", {31'd0, f_bd}, 32'h1);
        eret = 1'b1;
        #1;
        check("reset_bd_eret", {31'd0, f_bd}, 32'h0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("post_reset_seq", f_pc, 32'h3004);

        // Stall holds, exception overrides stall
        set_pc(32'h3020);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall%0d", k), f_pc, 32'h3020);
        end
        exc_req = 1'b1;
        tick();
        check("exc_during_stall", f_pc, 32'h4180);

        // eret held by stall, redirect on first enabled cycle
        set_pc(32'h3024);
        eret = 1'b1; epc = 32'h3050; en = 1'b0;
        tick();
        check("eret_stall0", f_pc, 32'h3024);
        tick();
        check("eret_stall1", f_pc, 32'h3024);
        en = 1'b1;
        tick();
        check("eret_release", f_pc, 32'h3050);

`ifdef IFU_ADEL_EN
        set_pc(32'h3002);
        i_rdata = 32'h1234_5678;
        #1;
        check("adel_misaligned_code", {27'd0, f_exccode}, 32'd4);
        check("adel_misaligned_instr", f_instr, 32'h0);
        check("adel_misaligned_pc", f_pc, 32'h3002);
        set_pc(32'h7000);
        #1;
        check("adel_high_code", {27'd0, f_exccode}, 32'd4);
        set_pc(32'h6FFC);
        #1;
        check("adel_top_ok", {27'd0, f_exccode}, 32'd0);
`else
        set_pc(32'h3002);
        i_rdata = 32'h1234_5678;
        #1;
        check("noadel_code", {27'd0, f_exccode}, 32'd0);
        check("noadel_instr", f_instr, 32'h1234_5678);
`endif

        // Randomized run against the reference model
        set_pc(32'h3000);
        model_pc = 32'h3000;
        for (int n = 0; n < 300; n++) begin
            en = ($urandom_range(0, 3) != 0);
            npc_sel = 2'($urandom_range(0, 3));
            br_taken = 1'($urandom);
            d_pc = 32'h3000 + 32'($urandom_range(0, 32'h3FFC));
            imm16 = 16'($urandom);
            index26 = 26'($urandom);
            jr_target = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 32'h4000));
            exc_req = ($urandom_range(0, 15) == 0);
            eret = ($urandom_range(0, 7) == 0);
            epc = 32'h3000 + 32'($urandom_range(0, 32'h3FFC));
            i_rdata = $urandom;
            #1;
            check("rnd_pc", f_pc, model_pc);
            check("rnd_bd", {31'd0, f_bd}, {31'd0, (npc_sel != 2'd0) && !eret});
`ifdef IFU_ADEL_EN
            check("rnd_instr", f_instr, is_adel(model_pc) ? 32'h0 : i_rdata);
            check("rnd_code", {27'd0, f_exccode}, is_adel(model_pc) ? 32'd4 : 32'd0);
`else
            check("rnd_instr", f_instr, i_rdata);
            check("rnd_code", {27'd0, f_exccode}, 32'd0);
`endif
            model_pc = ref_next(model_pc, en, npc_sel, br_taken, d_pc, imm16, index26,
                                jr_target, exc_req, eret, epc);
            tick();
        end
        check("rnd_final_pc", f_pc, model_pc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
